// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the PC, requests instruction words, holds them for decode,
// and applies branch redirects, halt/resume and a fetch-timeout error.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_take,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] fetch_count,
  output logic        fetch_err,
  output logic [1:0]  state
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     count_q, count_d;
  logic            err_q, err_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [31:0]     target;

  assign target = branch_base + branch_offset + 32'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    // Counter only survives consecutive unacknowledged FETCH cycles.
    tmo_d   = '0;
    case (state_q)
      StFetch: begin
        if (branch_take) begin
          pc_d = target;
        end else if (imem_ack) begin
          instr_d = imem_data;
          state_d = StHold;
        end else if (tmo_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StHold: begin
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_q + 32'd1;
          state_d = halt ? StHalt : StFetch;
        end
        // Without a handshake the held word is dropped uncounted.
        if (branch_take) begin
          pc_d    = target;
          state_d = (halt && instr_ready) ? StHalt : StFetch;
        end
      end
      StHalt: begin
        if (branch_take) pc_d = target;
        if (resume) begin
          state_d = StFetch;
          err_d   = 1'b0;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == StFetch);
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign fetch_count = count_q;
  assign fetch_err   = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer plus hand-written timeout/branch sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_take = 1'b0;
  logic [31:0] branch_base = '0;
  logic [31:0] branch_offset = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic        fetch_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_take  (branch_take),
    .branch_base  (branch_base),
    .branch_offset(branch_offset),
    .halt         (halt),
    .resume       (resume),
    .pc           (pc),
    .fetch_count  (fetch_count),
    .fetch_err    (fetch_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        br;
    logic [31:0] base;
    logic [31:0] off;
    logic        halt;
    logic        resume;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t mk(logic r, logic a, logic [31:0] d, logic rdy, logic b,
                             logic [31:0] bs, logic [31:0] of, logic h, logic rs);
    in_t v;
    v.rst_n = r; v.ack = a; v.data = d; v.ready = rdy; v.br = b;
    v.base = bs; v.off = of; v.halt = h; v.resume = rs;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input in_t i, input logic [31:0] p, input logic [1:0] s,
                     input logic [31:0] ins, input logic [31:0] c, input logic e);
    vec_t v;
    v.i = i; v.pc = p; v.st = s; v.instr = ins; v.cnt = c; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input in_t v);
    @(negedge clk);
    rst_n = v.rst_n; imem_ack = v.ack; imem_data = v.data; instr_ready = v.ready;
    branch_take = v.br; branch_base = v.base; branch_offset = v.off;
    halt = v.halt; resume = v.resume;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] p, input logic [1:0] s,
                           input logic [31:0] ins, input logic [31:0] c, input logic e);
    chk({tag, " pc"}, pc, p);
    chk({tag, " imem_addr"}, imem_addr, p);
    chk({tag, " state"}, 32'(state), 32'(s));
    chk({tag, " imem_req"}, 32'(imem_req), 32'(s == 2'd0));
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(s == 2'd1));
    chk({tag, " instr"}, instr, ins);
    chk({tag, " fetch_count"}, fetch_count, c);
    chk({tag, " fetch_err"}, 32'(fetch_err), 32'(e));
  endtask

  localparam logic [1:0] F = 2'd0, H = 2'd1, X = 2'd2;

  initial begin
    // Reset, then ack and ready held high: fetch 0..3 on alternate cycles.
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, F, 0, 0, 0);
    add(mk(1, 1, 32'hA0, 1, 0, 0, 0, 0, 0), 0, H, 32'hA0, 0, 0);
    add(mk(1, 1, 32'hA0, 1, 0, 0, 0, 0, 0), 1, F, 32'hA0, 1, 0);
    add(mk(1, 1, 32'hA1, 1, 0, 0, 0, 0, 0), 1, H, 32'hA1, 1, 0);
    add(mk(1, 1, 32'hA1, 1, 0, 0, 0, 0, 0), 2, F, 32'hA1, 2, 0);
    add(mk(1, 1, 32'hA2, 1, 0, 0, 0, 0, 0), 2, H, 32'hA2, 2, 0);
    add(mk(1, 1, 32'hA2, 1, 0, 0, 0, 0, 0), 3, F, 32'hA2, 3, 0);
    add(mk(1, 1, 32'hA3, 1, 0, 0, 0, 0, 0), 3, H, 32'hA3, 3, 0);
    add(mk(1, 1, 32'hA3, 1, 0, 0, 0, 0, 0), 4, F, 32'hA3, 4, 0);
    // Branches in FETCH; the same-cycle ack is discarded.
    add(mk(1, 1, 32'hDEAD, 0, 1, 10, 32'hFFFF_FFFB, 0, 0), 6, F, 32'hA3, 4, 0);
    add(mk(1, 0, 0, 0, 1, 10, 3, 0, 0), 14, F, 32'hA3, 4, 0);
    // Branch in HOLD without ready drops the word uncounted.
    add(mk(1, 1, 32'hB0, 0, 0, 0, 0, 0, 0), 14, H, 32'hB0, 4, 0);
    add(mk(1, 0, 0, 0, 1, 32'h100, 0, 0, 0), 32'h101, F, 32'hB0, 4, 0);
    // Halt at pc=5, then resume.
    add(mk(1, 0, 0, 0, 1, 4, 0, 0, 0), 5, F, 32'hB0, 4, 0);
    add(mk(1, 1, 32'hC5, 0, 0, 0, 0, 0, 0), 5, H, 32'hC5, 4, 0);
    add(mk(1, 0, 0, 1, 0, 0, 0, 1, 0), 6, X, 32'hC5, 5, 0);
    add(idle(), 6, X, 32'hC5, 5, 0);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 6, F, 32'hC5, 5, 0);
    add(mk(1, 1, 32'hC6, 0, 0, 0, 0, 0, 0), 6, H, 32'hC6, 5, 0);
    // Branch + ready + halt in HOLD: counted, goes to HALT at target.
    add(mk(1, 0, 0, 1, 1, 32'h1F, 0, 1, 0), 32'h20, X, 32'hC6, 6, 0);
    // Branch with resume in HALT: FETCH at the new target.
    add(mk(1, 0, 0, 0, 1, 32'h1F, 32'hFFFF_FFFF, 0, 1), 32'h1F, F, 32'hC6, 6, 0);
    add(mk(1, 1, 32'hD0, 0, 0, 0, 0, 0, 0), 32'h1F, H, 32'hD0, 6, 0);
    add(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 32'h20, F, 32'hD0, 7, 0);
    add(mk(1, 1, 32'hE0, 0, 0, 0, 0, 0, 0), 32'h20, H, 32'hE0, 7, 0);
    // Reset mid-HOLD.
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, F, 0, 0, 0);
    // halt in FETCH is ignored.
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), 0, F, 0, 0, 0);
    add(mk(1, 1, 32'hF0, 0, 0, 0, 0, 1, 0), 0, H, 32'hF0, 0, 0);
    add(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 1, F, 32'hF0, 1, 0);
    // PC wrap at 2^32.
    add(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0), 32'hFFFF_FFFF, F, 32'hF0, 1, 0);
    add(mk(1, 1, 32'h77, 0, 0, 0, 0, 0, 0), 32'hFFFF_FFFF, H, 32'h77, 1, 0);
    add(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 0, F, 32'h77, 2, 0);

    foreach (vecs[k]) begin
      step(vecs[k].i);
      check_out($sformatf("vec%0d", k), vecs[k].pc, vecs[k].st, vecs[k].instr,
                vecs[k].cnt, vecs[k].err);
    end

    // Timeout: exactly 16 FETCH cycles without ack.
    for (int n = 0; n < 15; n++) step(idle());
    check_out("tmo_pre", 0, F, 32'h77, 2, 0);
    step(idle());
    check_out("tmo_hit", 0, X, 32'h77, 2, 1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    check_out("tmo_resume", 0, F, 32'h77, 2, 0);

    // Branch on the would-be timeout cycle wins and restarts the count.
    for (int n = 0; n < 15; n++) step(idle());
    step(mk(1, 0, 0, 0, 1, 32'h40, 0, 0, 0));
    check_out("tmo_branch", 32'h41, F, 32'h77, 2, 0);
    for (int n = 0; n < 15; n++) step(idle());
    check_out("tmo2_pre", 32'h41, F, 32'h77, 2, 0);
    step(idle());
    check_out("tmo2_hit", 32'h41, X, 32'h77, 2, 1);
    // Branch in HALT keeps the sticky error until resume.
    step(mk(1, 0, 0, 0, 1, 32'h80, 0, 0, 0));
    check_out("halt_branch", 32'h81, X, 32'h77, 2, 1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    check_out("halt_resume", 32'h81, F, 32'h77, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
